// File: rtl/div_init_pkg.sv
// Shared types and constants for the divider bus initiator.
// Optional build macro: DIV_INIT_ZERO_CHECK_EN (local divide-by-zero response).
package div_init_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CLEAR,
        WAIT,
        READ,
        CAPTURE,
        RESP
    } state_t;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 12;
    localparam logic [4:0] DIV_ADDR_DEFAULT = 5'h00;

    // Result layout returned by the divider peripheral
    localparam int Q_MSB = 15;
    localparam int Q_LSB = 8;
    localparam int R_MSB = 7;
    localparam int R_LSB = 0;

endpackage

// File: rtl/div_init_wait_cnt.sv
// Loadable 8-bit down-counter; done marks the last wait cycle.
module div_init_wait_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign done = (cnt == 8'd1);

endmodule

// File: rtl/div_bus_initiator.sv
// Runs one 8-bit division on the divider peripheral over the peripheral bus.
// Optional build macro: DIV_INIT_ZERO_CHECK_EN (zero divisor answered locally).
module div_bus_initiator
    import div_init_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter logic [4:0]  DIV_ADDR    = DIV_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_q,
    output logic [7:0]  rsp_r,
    output logic        rsp_err,
    output logic        busy,
    output logic        bus_cs,
    output logic [4:0]  bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

    state_t state;
    logic   cnt_done;
    logic   zero_div;
    logic   unused_rdata;

    assign unused_rdata = ^bus_rdata[31:16];

`ifdef DIV_INIT_ZERO_CHECK_EN
    assign zero_div = (req_b == 8'd0);
`else
    assign zero_div = 1'b0;
`endif

    div_init_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state == CLEAR),
        .load_val (WAIT_LOAD),
        .en       (state == WAIT),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_q     <= 8'd0;
            rsp_r     <= 8'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            bus_cs    <= 1'b0;
            bus_addr  <= 5'd0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_wdata <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        bus_wdata <= {req_a, req_b};
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (zero_div) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_q     <= 8'hFF;
                            rsp_r     <= req_a;
                            rsp_err   <= 1'b1;
                        end else begin
                            state    <= WRITE;
                            bus_cs   <= 1'b1;
                            bus_wr   <= 1'b1;
                            bus_addr <= DIV_ADDR;
                        end
                    end
                end
                WRITE: begin
                    // Keep cs for one more cycle so the peripheral sees start drop
                    state  <= CLEAR;
                    bus_wr <= 1'b0;
                end
                CLEAR: begin
                    state    <= WAIT;
                    bus_cs   <= 1'b0;
                    bus_addr <= 5'd0;
                end
                WAIT: begin
                    if (cnt_done) begin
                        state    <= READ;
                        bus_cs   <= 1'b1;
                        bus_rd   <= 1'b1;
                        bus_addr <= DIV_ADDR;
                    end
                end
                READ: begin
                    state    <= CAPTURE;
                    bus_cs   <= 1'b0;
                    bus_rd   <= 1'b0;
                    bus_addr <= 5'd0;
                end
                CAPTURE: begin
                    state     <= RESP;
                    rsp_q     <= bus_rdata[Q_MSB:Q_LSB];
                    rsp_r     <= bus_rdata[R_MSB:R_LSB];
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_bus_initiator.sv
// Directed bench for div_bus_initiator with a simple divider peripheral model.
// Honours DIV_INIT_ZERO_CHECK_EN for the zero-divisor expectations.
module tb_div_bus_initiator;

    localparam logic [4:0] TB_ADDR = 5'h0A;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_q;
    logic [7:0]  rsp_r;
    logic        rsp_err;
    logic        busy;
    logic        bus_cs;
    logic [4:0]  bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_wdata;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    int wr_cnt = 0;
    int rd_cnt = 0;
    int clr_cnt = 0;
    int cs_cnt = 0;
    int proto_err = 0;

    logic [7:0] op_a;
    logic [7:0] op_b;

    div_bus_initiator #(
        .WAIT_CYCLES (12),
        .DIV_ADDR    (TB_ADDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .bus_cs    (bus_cs),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider peripheral: latches operands on write, registers result on read
    initial begin
        op_a = 8'd0;
        op_b = 8'd0;
        bus_rdata = 32'hA5A5_A5A5;
    end

    always @(posedge clk) begin
        if (bus_cs && bus_wr) begin
            op_a <= bus_wdata[15:8];
            op_b <= bus_wdata[7:0];
            bus_rdata <= 32'h0000_5A5A;
        end else if (bus_cs && bus_rd) begin
            if (op_b == 8'd0)
                bus_rdata <= {16'hBEEF, 8'hFF, op_a};
            else
                bus_rdata <= {16'hBEEF, op_a / op_b, op_a % op_b};
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_wr) wr_cnt++;
            if (bus_rd) rd_cnt++;
            if (bus_cs) cs_cnt++;
            if (bus_cs && !bus_wr && !bus_rd) clr_cnt++;
            if (bus_wr && bus_rd) proto_err++;
            if (!bus_cs && bus_addr != 5'd0) proto_err++;
            if (bus_cs && bus_addr != TB_ADDR) proto_err++;
        end
    end

    // Called at posedge+1; returns at accept edge (E0)+1
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        output bit ok);
        int n = 0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0;
        req_a = 8'd0;
        req_b = 8'd0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, busy, bus_cs, bus_rd, bus_wr}
            !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                {req_ready, rsp_valid, rsp_err, busy, bus_cs, bus_rd, bus_wr});
        end
        n_cmp++;
        if ({rsp_q, rsp_r, bus_addr, bus_wdata} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0",
                {rsp_q, rsp_r, bus_addr, bus_wdata});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit ok;
        int n;
        int wr0 = wr_cnt;
        int rd0 = rd_cnt;
        int cl0 = clr_cnt;
        rsp_ready = 1'b1;
        send(8'd100, 8'd7, ok);
        n_cmp++;
        if ({ok, bus_cs, bus_wr, bus_rd, req_ready, busy} !== 6'b111001) begin
            n_bad++;
            $display("FAIL basic_write_ctrl: got %b want 111001",
                {ok, bus_cs, bus_wr, bus_rd, req_ready, busy});
        end
        n_cmp++;
        if (bus_wdata !== 16'h6407) begin
            n_bad++;
            $display("FAIL basic_wdata: got %h want 6407", bus_wdata);
        end
        wait_rsp(n);
        n_cmp++;
        if (n !== 16) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d want 16", n);
        end
        n_cmp++;
        if ({rsp_q, rsp_r, rsp_err} !== {8'd14, 8'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_result: got q=%0d r=%0d e=%0d want 14 2 0",
                rsp_q, rsp_r, rsp_err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({rsp_valid, req_ready, busy, rsp_q} !== {3'b010, 8'd14}) begin
            n_bad++;
            $display("FAIL basic_handshake: got v=%0d rdy=%0d busy=%0d q=%0d want 0 1 0 14",
                rsp_valid, req_ready, busy, rsp_q);
        end
        n_cmp++;
        if ({wr_cnt - wr0, rd_cnt - rd0, clr_cnt - cl0} !== {32'd1, 32'd1, 32'd1}) begin
            n_bad++;
            $display("FAIL basic_bus_cycles: got wr=%0d rd=%0d clr=%0d want 1 1 1",
                wr_cnt - wr0, rd_cnt - rd0, clr_cnt - cl0);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        rsp_ready = 1'b0;
        send(8'd255, 8'd1, ok);
        wait_rsp(n);
        n_cmp++;
        if ({rsp_valid, rsp_q, rsp_r} !== {1'b1, 8'd255, 8'd0}) begin
            n_bad++;
            $display("FAIL bp_result: got v=%0d q=%0d r=%0d want 1 255 0",
                rsp_valid, rsp_q, rsp_r);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rsp_valid, req_ready, rsp_q, rsp_r} !== {2'b10, 8'd255, 8'd0}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%0d rdy=%0d q=%0d r=%0d want 1 0 255 0",
                    i, rsp_valid, req_ready, rsp_q, rsp_r);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release: got v=%0d rdy=%0d want 0 1",
                rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int n;
        rsp_ready = 1'b1;
        send(8'd200, 8'd9, ok);
        wait_rsp(n);
        n_cmp++;
        if ({rsp_q, rsp_r} !== {8'd22, 8'd2}) begin
            n_bad++;
            $display("FAIL b2b_first: got q=%0d r=%0d want 22 2", rsp_q, rsp_r);
        end
        req_valid = 1'b1;
        req_a = 8'd17;
        req_b = 8'd17;
        @(posedge clk); #1;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_handshake: got v=%0d rdy=%0d want 0 1",
                rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++;
        if ({req_ready, bus_wr, bus_wdata} !== {2'b01, 16'h1111}) begin
            n_bad++;
            $display("FAIL b2b_accept: got rdy=%0d wr=%0d wdata=%h want 0 1 1111",
                req_ready, bus_wr, bus_wdata);
        end
        wait_rsp(n);
        n_cmp++;
        if ({n[7:0], rsp_q, rsp_r} !== {8'd16, 8'd1, 8'd0}) begin
            n_bad++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want 16 1 0",
                n, rsp_q, rsp_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        int rd0;
        rsp_ready = 1'b1;
        send(8'd50, 8'd3, ok);
        repeat (5) @(posedge clk);
        #3;
        rd0 = rd_cnt;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, busy, bus_cs, bus_rd, bus_wr,
             bus_addr, bus_wdata} !== {7'b1000000, 5'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL midreset_outputs: rdy=%0d v=%0d busy=%0d cs=%0d addr=%h wdata=%h",
                req_ready, rsp_valid, busy, bus_cs, bus_addr, bus_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if ({rd_cnt - rd0, 31'd0, rsp_valid, busy} !== {32'd0, 31'd0, 2'b00}) begin
            n_bad++;
            $display("FAIL midreset_quiet: got rd=%0d v=%0d busy=%0d want 0 0 0",
                rd_cnt - rd0, rsp_valid, busy);
        end
        send(8'd50, 8'd3, ok);
        wait_rsp(n);
        n_cmp++;
        if ({n[7:0], rsp_q, rsp_r} !== {8'd16, 8'd16, 8'd2}) begin
            n_bad++;
            $display("FAIL midreset_retry: got lat=%0d q=%0d r=%0d want 16 16 2",
                n, rsp_q, rsp_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_div;
        bit ok;
        int n;
        int cs0 = cs_cnt;
        int wr0 = wr_cnt;
        int rd0 = rd_cnt;
        rsp_ready = 1'b1;
        send(8'd42, 8'd0, ok);
`ifdef DIV_INIT_ZERO_CHECK_EN
        n_cmp++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_err, bus_cs} !== {1'b1, 8'hFF, 8'd42, 2'b10}) begin
            n_bad++;
            $display("FAIL zero_local: got v=%0d q=%h r=%0d e=%0d cs=%0d want 1 ff 42 1 0",
                rsp_valid, rsp_q, rsp_r, rsp_err, bus_cs);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({cs_cnt - cs0, 31'd0, rsp_valid} !== {32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL zero_no_bus: got cs_cycles=%0d v=%0d want 0 0",
                cs_cnt - cs0, rsp_valid);
        end
`else
        wait_rsp(n);
        n_cmp++;
        if ({n[7:0], rsp_q, rsp_r, rsp_err} !== {8'd16, 8'hFF, 8'd42, 1'b0}) begin
            n_bad++;
            $display("FAIL zero_bus: got lat=%0d q=%h r=%0d e=%0d want 16 ff 42 0",
                n, rsp_q, rsp_r, rsp_err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({wr_cnt - wr0, rd_cnt - rd0, cs_cnt - cs0} !== {32'd1, 32'd1, 32'd3}) begin
            n_bad++;
            $display("FAIL zero_bus_cycles: got wr=%0d rd=%0d cs=%0d want 1 1 3",
                wr_cnt - wr0, rd_cnt - rd0, cs_cnt - cs0);
        end
`endif
        send(8'd9, 8'd4, ok);
        wait_rsp(n);
        n_cmp++;
        if ({rsp_q, rsp_r, rsp_err} !== {8'd2, 8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL zero_then_normal: got q=%0d r=%0d e=%0d want 2 1 0",
                rsp_q, rsp_r, rsp_err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_zero_div();
        n_cmp++;
        if (proto_err !== 0) begin
            n_bad++;
            $display("FAIL bus_protocol: got %0d violations want 0", proto_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
